pong_match_controller: RTL

Match sequencer for the pong design. It owns the game state (attract, serve delay, rally, game over) and keeps the score. It schedules ball motion by issuing one-cycle step strobes whose period shortens with each paddle hit. It sits between the player/button inputs and the game engine, which reports hit and miss pulses back to it.

---
 rtl/pong_match_controller.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pong_match_controller.sv
// rtl/pong_match_controller.sv - pong match sequencer: game state, score and ball-step scheduling
module pong_match_controller #(
  parameter int STEP_PERIOD = 91072,
  parameter int MIN_PERIOD  = 30000,
  parameter int SPEEDUP     = 2048,
  parameter int SERVE_DELAY = 67108863,
  parameter int WIN_SCORE   = 9
) (
  input  logic       VGA_CLOCK,
  input  logic       RESET,
  input  logic       START,
  input  logic       PAUSE,
  input  logic       HIT_A,
  input  logic       HIT_B,
  input  logic       MISS_A,
  input  logic       MISS_B,
  output logic       BALL_STEP,
  output logic       SERVE,
  output logic       SERVE_DIR,
  output logic       BALL_VISIBLE,
  output logic [3:0] SCORE_A,
  output logic [3:0] SCORE_B,
  output logic [1:0] WINNER,
  output logic [1:0] STATE
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SERVE = 2'b01;
  localparam logic [1:0] ST_PLAY  = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;

  localparam logic [16:0] STEP_P  = STEP_PERIOD[16:0];
  localparam logic [16:0] MIN_P   = MIN_PERIOD[16:0];
  localparam logic [16:0] SPEED_P = SPEEDUP[16:0];
  localparam logic [27:0] DELAY_P = SERVE_DELAY[27:0];
  localparam logic [3:0]  WIN_P   = WIN_SCORE[3:0];

  logic [1:0]  state_q, state_d;
  logic        start_q;
  logic [3:0]  score_a_q, score_a_d, score_b_q, score_b_d;
  logic [1:0]  winner_q, winner_d;
  logic        serve_q, serve_d, serve_dir_q, serve_dir_d;
  logic        ball_step_q, ball_step_d, visible_q, visible_d;
  logic [27:0] delay_q, delay_d;
  logic [16:0] step_cnt_q, step_cnt_d;
  logic [16:0] period_q, period_d;

  logic        start_rise, reserve, hit;
  logic [16:0] sped_period;

  assign start_rise = START & ~start_q;
  assign hit        = HIT_A | HIT_B;
  // Saturate at the floor without letting the subtraction wrap.
  assign sped_period = ({1'b0, period_q} < ({1'b0, MIN_P} + {1'b0, SPEED_P}))
                       ? MIN_P : (period_q - SPEED_P);

  always_comb begin
    state_d     = state_q;
    score_a_d   = score_a_q;
    score_b_d   = score_b_q;
    winner_d    = winner_q;
    serve_d     = 1'b0;
    serve_dir_d = serve_dir_q;
    ball_step_d = 1'b0;
    delay_d     = delay_q;
    step_cnt_d  = step_cnt_q;
    period_d    = period_q;
    reserve     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          score_a_d   = 4'd0;
          score_b_d   = 4'd0;
          winner_d    = 2'b00;
          serve_dir_d = 1'b1;
          reserve     = 1'b1;
        end
      end
      ST_SERVE: begin
        if (!PAUSE) begin
          if (delay_q == 28'd1) begin
            state_d    = ST_PLAY;
            step_cnt_d = 17'd0;
          end else begin
            delay_d = delay_q - 28'd1;
          end
        end
      end
      ST_PLAY: begin
        if (!PAUSE) begin
          if (MISS_A && MISS_B) begin
            reserve = 1'b1;
          end else if (MISS_A) begin
            score_b_d   = score_b_q + 4'd1;
            serve_dir_d = 1'b0;
            if (score_b_q + 4'd1 == WIN_P) begin
              winner_d = 2'b10;
              state_d  = ST_OVER;
            end else begin
              reserve = 1'b1;
            end
          end else if (MISS_B) begin
            score_a_d   = score_a_q + 4'd1;
            serve_dir_d = 1'b1;
            if (score_a_q + 4'd1 == WIN_P) begin
              winner_d = 2'b01;
              state_d  = ST_OVER;
            end else begin
              reserve = 1'b1;
            end
          end else begin
            if (hit) period_d = sped_period;
            // >= so a shortened period overtaken by the counter strobes at once
            if (step_cnt_q >= period_q - 17'd1) begin
              ball_step_d = 1'b1;
              step_cnt_d  = 17'd0;
            end else begin
              step_cnt_d = step_cnt_q + 17'd1;
            end
          end
        end
      end
      default: begin
        if (start_rise) state_d = ST_IDLE;
      end
    endcase

    if (reserve) begin
      serve_d  = 1'b1;
      state_d  = ST_SERVE;
      delay_d  = DELAY_P;
      period_d = STEP_P;
    end

    visible_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      score_a_q   <= 4'd0;
      score_b_q   <= 4'd0;
      winner_q    <= 2'b00;
      serve_q     <= 1'b0;
      serve_dir_q <= 1'b1;
      ball_step_q <= 1'b0;
      visible_q   <= 1'b0;
      delay_q     <= 28'd0;
      step_cnt_q  <= 17'd0;
      period_q    <= STEP_P;
    end else begin
      state_q     <= state_d;
      start_q     <= START;
      score_a_q   <= score_a_d;
      score_b_q   <= score_b_d;
      winner_q    <= winner_d;
      serve_q     <= serve_d;
      serve_dir_q <= serve_dir_d;
      ball_step_q <= ball_step_d;
      visible_q   <= visible_d;
      delay_q     <= delay_d;
      step_cnt_q  <= step_cnt_d;
      period_q    <= period_d;
    end
  end

  assign BALL_STEP    = ball_step_q;
  assign SERVE        = serve_q;
  assign SERVE_DIR    = serve_dir_q;
  assign BALL_VISIBLE = visible_q;
  assign SCORE_A      = score_a_q;
  assign SCORE_B      = score_b_q;
  assign WINNER       = winner_q;
  assign STATE        = state_q;

endmodule
